// File: rtl/lw_sha_ahb_mc_bridge.sv
// lw_sha_ahb_mc_bridge: AHB-Lite slave feeding one hash core from NUM_CH round-robin scheduled word FIFOs
module lw_sha_ahb_mc_bridge #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CH      = 4,
  parameter int FIFO_DEPTH  = 16,
  parameter int BLOCK_WORDS = 16,
  parameter int ADDR_WIDTH  = 12,
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic                  hwrite,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic                  core_valid_o,
  input  logic                  core_ready_i,
  output logic [DATA_WIDTH-1:0] core_data_o,
  output logic                  core_sob_o,
  output logic                  core_last_o,
  output logic [CW-1:0]         core_ch_o,
  output logic                  core_abort_o,
  input  logic                  core_done_i,
  input  logic [CW-1:0]         core_done_ch_i,
  output logic                  irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(DATA_WIDTH / 8);
  localparam int FW = ADDR_WIDTH - 6;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state_q, state_d;
  logic                    dp_q, wr_q, bad_q, err2_q, irq_q;
  logic [FW-1:0]           chan_q;
  logic [5:0]              slot_q;
  logic [CW-1:0]           grant_q, grant_d, rr_q, rr_d, pick, chi;
  logic [LW-1:0]           bcnt_q, bcnt_d;
  logic [LW-1:0]           level_q [NUM_CH];
  logic [LW-1:0]           lastcnt_q [NUM_CH];
  logic [AW-1:0]           wp_q [NUM_CH];
  logic [AW-1:0]           rp_q [NUM_CH];
  logic [DATA_WIDTH:0]     mem_q [NUM_CH][FIFO_DEPTH];
  logic [NUM_CH-1:0]       ovf_q, stat_q, stat_d, en_q, elig, push_c, pop_c, fl_c;
  logic                    cap, glob, ch_ok, is_push, err, push_ok, ctrl_wr, flush, clrov;
  logic                    flush_g, pop, blk_end, pick_ok, gw0, gw1;
  logic [DATA_WIDTH:0]     head;
  logic [DATA_WIDTH-1:0]   rdv;

  assign cap     = hsel & hready & (htrans inside {2'b10, 2'b11});
  assign glob    = chan_q == FW'(63);
  assign ch_ok   = chan_q < FW'(NUM_CH);
  assign chi     = chan_q[CW-1:0];
  assign is_push = dp_q & wr_q & ch_ok & (slot_q < 6'd2);
  assign err     = dp_q & (bad_q | (is_push & (level_q[chi] == LW'(FIFO_DEPTH))));
  assign push_ok = is_push & ~err;
  assign ctrl_wr = dp_q & wr_q & ch_ok & ~bad_q & (slot_q == 6'd3);
  assign flush   = ctrl_wr & hwdata[0];
  assign clrov   = ctrl_wr & hwdata[1];
  assign gw0     = dp_q & wr_q & ~bad_q & glob & (slot_q == 6'd0);
  assign gw1     = dp_q & wr_q & ~bad_q & glob & (slot_q == 6'd1);
  assign flush_g = flush & (state_q == STREAM) & (chi == grant_q);
  assign head    = mem_q[grant_q][rp_q[grant_q]];

  assign core_valid_o = (state_q == STREAM) & (level_q[grant_q] != '0) & ~flush_g;
  assign pop          = core_valid_o & core_ready_i;
  assign blk_end      = pop & ((bcnt_q == LW'(BLOCK_WORDS - 1)) | head[DATA_WIDTH]);
  assign core_data_o  = core_valid_o ? head[DATA_WIDTH-1:0] : '0;
  assign core_last_o  = core_valid_o & head[DATA_WIDTH];
  assign core_sob_o   = core_valid_o & (bcnt_q == '0);
  assign core_ch_o    = core_valid_o ? grant_q : '0;
  assign core_abort_o = flush_g;

  assign rdv = glob ? (slot_q == 6'd0 ? DATA_WIDTH'(stat_q) : slot_q == 6'd1 ? DATA_WIDTH'(en_q) : '0)
             : (ch_ok && slot_q == 6'd2) ? DATA_WIDTH'({ovf_q[chi], (state_q == STREAM) && (grant_q == chi),
                 level_q[chi] == '0, level_q[chi] == LW'(FIFO_DEPTH), 16'(level_q[chi])}) : '0;
  assign hrdata    = (dp_q & ~wr_q & ~bad_q) ? rdv : '0;
  assign hreadyout = ~err;
  assign hresp     = err | err2_q;
  assign irq_o     = irq_q;
  assign stat_d    = (stat_q & ~(gw0 ? hwdata[NUM_CH-1:0] : '0)) | (core_done_i ? NUM_CH'(1) << core_done_ch_i : '0);

  // per-channel strobes, eligibility and round-robin pick starting at rr_q
  always_comb begin
    push_c  = '0;
    pop_c   = '0;
    fl_c    = '0;
    elig    = '0;
    pick_ok = 1'b0;
    pick    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      push_c[i] = push_ok && chi == CW'(i);
      pop_c[i]  = pop && grant_q == CW'(i);
      fl_c[i]   = flush && chi == CW'(i);
      elig[i]   = (level_q[i] >= LW'(BLOCK_WORDS)) || (lastcnt_q[i] != '0);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!pick_ok && elig[(int'(rr_q) + i) % NUM_CH]) begin
        pick_ok = 1'b1;
        pick    = CW'((int'(rr_q) + i) % NUM_CH);
      end
    end
  end

  // scheduler next state: grant in IDLE, count beats and end or abort blocks in STREAM
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    bcnt_d  = bcnt_q;
    if (state_q == IDLE) begin
      if (pick_ok) begin
        state_d = STREAM;
        grant_d = pick;
        bcnt_d  = '0;
      end
    end else if (flush_g) begin
      state_d = IDLE;
      bcnt_d  = '0;
    end else if (blk_end) begin
      state_d = IDLE;
      rr_d    = grant_q == CW'(NUM_CH - 1) ? '0 : grant_q + 1'b1;
      bcnt_d  = '0;
    end else if (pop) begin
      bcnt_d = bcnt_q + 1'b1;
    end
  end

  // AHB address-phase capture and error second-cycle flag
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_q   <= 1'b0;
      wr_q   <= 1'b0;
      bad_q  <= 1'b0;
      err2_q <= 1'b0;
      chan_q <= '0;
      slot_q <= '0;
    end else begin
      dp_q   <= cap;
      err2_q <= err;
      if (cap) begin
        wr_q   <= hwrite;
        chan_q <= haddr[ADDR_WIDTH-1:6];
        slot_q <= haddr[5:0] >> BW;
        bad_q  <= (haddr[ADDR_WIDTH-1:6] >= FW'(NUM_CH) && haddr[ADDR_WIDTH-1:6] != FW'(63)) || hsize != 3'(BW);
      end
    end
  end

  // scheduler state and interrupt registers
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      bcnt_q  <= '0;
      stat_q  <= '0;
      en_q    <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      bcnt_q  <= bcnt_d;
      stat_q  <= stat_d;
      en_q    <= gw1 ? hwdata[NUM_CH-1:0] : en_q;
      irq_q   <= |(stat_q & en_q);
    end
  end

  // FIFO pointers, levels, last-word counts and sticky overflow per channel
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wp_q[c]      <= '0;
        rp_q[c]      <= '0;
        level_q[c]   <= '0;
        lastcnt_q[c] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (fl_c[c]) begin
          wp_q[c]      <= '0;
          rp_q[c]      <= '0;
          level_q[c]   <= '0;
          lastcnt_q[c] <= '0;
        end else begin
          wp_q[c]      <= wp_q[c] + AW'(push_c[c]);
          rp_q[c]      <= rp_q[c] + AW'(pop_c[c]);
          level_q[c]   <= level_q[c] + LW'(push_c[c]) - LW'(pop_c[c]);
          lastcnt_q[c] <= lastcnt_q[c] + LW'(push_c[c] & slot_q[0]) - LW'(pop_c[c] & head[DATA_WIDTH]);
        end
        ovf_q[c] <= (clrov && chi == CW'(c)) ? 1'b0 : (is_push && err && chi == CW'(c)) ? 1'b1 : ovf_q[c];
      end
    end
  end

  // FIFO storage, entry = {last, data}
  always_ff @(posedge hclk) begin
    if (push_ok) mem_q[chi][wp_q[chi]] <= {slot_q[0], hwdata};
  end
endmodule
